// File: rtl/kong_pkg.sv
// Shared Kong constants and types used by the intro animation and its draw stage.
package kong_pkg;

  localparam logic [10:0] KONG_ANIMATION_INITIAL_XPOS = 11'd400;
  localparam logic [10:0] KONG_ANIMATION_INITIAL_YPOS = 11'd600;
  localparam logic [10:0] KONG_PLATFORM_YPOS          = 11'd150;

  localparam int          KONG_SPRITE_W    = 48;
  localparam int          KONG_SPRITE_H    = 48;
  localparam int          KONG_CLIMB_STEP  = 8;
  localparam logic [11:0] KONG_TRANSPARENT = 12'hF0F;

  typedef enum logic [1:0] {FR_STAND, FR_CLIMB_A, FR_CLIMB_B, FR_JUMP} KONG_FRAME_T;

  function automatic logic kong_is_climb(input KONG_FRAME_T fr);
    return (fr == FR_CLIMB_A) || (fr == FR_CLIMB_B);
  endfunction

endpackage

// File: rtl/delay.sv
// Generic clearable shift register used to align timing and colour with the sprite pipeline.
module delay #(
  parameter int WIDTH   = 8,
  parameter int CLK_DEL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe_q [CLK_DEL];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CLK_DEL; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= din;
      for (int i = 1; i < CLK_DEL; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign dout = pipe_q[CLK_DEL-1];

endmodule

// File: rtl/draw_kong.sv
// Kong sprite overlay: per-frame pose selection, sprite-ROM addressing and 3-cycle compositing.
module draw_kong
  import kong_pkg::*;
#(
  parameter int          SPRITE_W    = KONG_SPRITE_W,
  parameter int          SPRITE_H    = KONG_SPRITE_H,
  parameter int          CLIMB_STEP  = KONG_CLIMB_STEP,
  parameter logic [11:0] TRANSPARENT = KONG_TRANSPARENT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        animation,
  input  logic        is_on_ladder,
  input  logic [10:0] xpos,
  input  logic [10:0] ypos,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [11:0] rom_data,
  output logic [13:0] rom_addr,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  logic [10:0] x_q, x_d, y_q, y_d, climb_ref_q, climb_ref_d;
  KONG_FRAME_T frame_q, frame_d;
  logic        latch;
  logic [10:0] ydiff;

  assign latch = (hcount_in == 11'd0) && (vcount_in == 11'd0);
  assign ydiff = (ypos >= climb_ref_q) ? (ypos - climb_ref_q) : (climb_ref_q - ypos);

  // The pixel at (0,0) already sees the freshly latched position and pose.
  always_comb begin
    x_d         = x_q;
    y_d         = y_q;
    frame_d     = frame_q;
    climb_ref_d = climb_ref_q;
    if (latch) begin
      x_d = xpos;
      y_d = ypos;
      if (!animation) begin
        frame_d = FR_STAND;
      end else if (is_on_ladder) begin
        if (!kong_is_climb(frame_q)) begin
          frame_d     = FR_CLIMB_A;
          climb_ref_d = ypos;
        end else if (ydiff >= 11'(CLIMB_STEP)) begin
          frame_d     = (frame_q == FR_CLIMB_A) ? FR_CLIMB_B : FR_CLIMB_A;
          climb_ref_d = ypos;
        end
      end else begin
        frame_d = (ypos < KONG_PLATFORM_YPOS) ? FR_JUMP : FR_STAND;
      end
    end
  end

  // 12-bit bounds so a sprite near the right/bottom edge clips instead of wrapping.
  logic [11:0] h12, v12, x12, y12;
  logic        hit_p0;
  logic [10:0] row_p0, col_p0;
  logic [13:0] addr_p0;

  assign h12    = {1'b0, hcount_in};
  assign v12    = {1'b0, vcount_in};
  assign x12    = {1'b0, x_d};
  assign y12    = {1'b0, y_d};
  assign hit_p0 = (h12 >= x12) && (h12 < x12 + 12'(SPRITE_W)) &&
                  (v12 >= y12) && (v12 < y12 + 12'(SPRITE_H));
  assign row_p0 = vcount_in - y_d;
  assign col_p0 = hcount_in - x_d;
  assign addr_p0 = hit_p0 ? ({12'd0, frame_d} * 14'(SPRITE_W * SPRITE_H) +
                             {3'd0, row_p0} * 14'(SPRITE_W) + {3'd0, col_p0}) : 14'd0;

  logic [13:0] rom_addr_q;
  logic        hit_p1, hit_p2;

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q         <= KONG_ANIMATION_INITIAL_XPOS;
      y_q         <= KONG_ANIMATION_INITIAL_YPOS;
      frame_q     <= FR_STAND;
      climb_ref_q <= 11'd0;
      rom_addr_q  <= 14'd0;
      hit_p1      <= 1'b0;
      hit_p2      <= 1'b0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      frame_q     <= frame_d;
      climb_ref_q <= climb_ref_d;
      // ---- stage 1: address to ROM ----
      rom_addr_q  <= addr_p0;
      hit_p1      <= hit_p0;
      // ---- stage 2: ROM data arrives ----
      hit_p2      <= hit_p1;
    end
  end

  assign rom_addr = rom_addr_q;

  logic [37:0] tim_p2;
  logic [10:0] hcount_p2, vcount_p2;
  logic        hsync_p2, vsync_p2, hblnk_p2, vblnk_p2;
  logic [11:0] rgb_p2, rgb_d;

  delay #(.WIDTH(38), .CLK_DEL(2)) u_timing_delay (
    .clk  (clk),
    .rst  (rst),
    .din  ({hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in}),
    .dout (tim_p2)
  );

  assign {hcount_p2, vcount_p2, hsync_p2, vsync_p2, hblnk_p2, vblnk_p2, rgb_p2} = tim_p2;
  assign rgb_d = (hblnk_p2 || vblnk_p2)             ? 12'h000  :
                 (hit_p2 && rom_data != TRANSPARENT) ? rom_data : rgb_p2;

  // ---- stage 3: composited output ----
  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_out <= 11'd0;
      vcount_out <= 11'd0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= 12'h000;
    end else begin
      hcount_out <= hcount_p2;
      vcount_out <= vcount_p2;
      hsync_out  <= hsync_p2;
      vsync_out  <= vsync_p2;
      hblnk_out  <= hblnk_p2;
      vblnk_out  <= vblnk_p2;
      rgb_out    <= rgb_d;
    end
  end

endmodule
